// File: rtl/pipeline_decode.sv
// RV32I decode stage: register file read, immediate and control generation into the ID/EX register.
// Latency: 1 cycle from instruction_i/pc_i to the ID/EX outputs.
// Backpressure: stall_o (combinational) holds fetch on load-use; without DECODE_WB_BYPASS_EN it also holds on a same-cycle write-back collision.
module pipeline_decode #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [3:0]      alu_op_o,
    output logic            alusrc_o,
    output logic            auipc_o,
    output logic            memread_o,
    output logic            memwrite_o,
    output logic            regwrite_o,
    output logic            memtoreg_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Control bundle carried into ID/EX; zeroed as a whole to form a bubble.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alusrc;
        logic       auipc;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    logic [XLEN-1:0] rf_q [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic            use_rs1;
    logic            use_rs2;
    ctrl_t           ctrl_d;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;
    logic            hazard_lu;
    logic            hazard_wb;
    logic            wb_hit_rs1;
    logic            wb_hit_rs2;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;

    assign opcode    = instruction_i[6:0];
    assign rd_idx    = instruction_i[11:7];
    assign funct3    = instruction_i[14:12];
    assign rs1_idx   = instruction_i[19:15];
    assign rs2_idx   = instruction_i[24:20];
    assign funct7_b5 = instruction_i[30];

    // Map funct3 to an ALU op; alt selects SUB for 000 and SRA for 101.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    // Opcode decode: immediate format, control bundle and which sources are actually read.
    always_comb begin
        ctrl_d  = '0;
        imm_d   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_d           = {instruction_i[31:12], 12'b0};
                ctrl_d.alu_op   = ALU_PASSB;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                imm_d           = {instruction_i[31:12], 12'b0};
                ctrl_d.alu_op   = ALU_ADD;
                ctrl_d.auipc    = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OPC_JAL: begin
                imm_d           = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                                   instruction_i[20], instruction_i[30:21], 1'b0};
                ctrl_d.jump     = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            OPC_JALR: begin
                imm_d           = {{20{instruction_i[31]}}, instruction_i[31:20]};
                ctrl_d.jump     = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                use_rs1         = 1'b1;
            end
            OPC_BRANCH: begin
                imm_d           = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                                   instruction_i[30:25], instruction_i[11:8], 1'b0};
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_op   = ALU_SUB;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OPC_LOAD: begin
                imm_d           = {{20{instruction_i[31]}}, instruction_i[31:20]};
                ctrl_d.alu_op   = ALU_ADD;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memread  = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
                use_rs1         = 1'b1;
            end
            OPC_STORE: begin
                imm_d           = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
                ctrl_d.alu_op   = ALU_ADD;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OPC_OPIMM: begin
                imm_d           = {{20{instruction_i[31]}}, instruction_i[31:20]};
                // ADDI has no subtract form; only the shift-right immediate uses funct7[5].
                ctrl_d.alu_op   = alu_from_f3(funct3, funct7_b5 && (funct3 == 3'b101));
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                use_rs1         = 1'b1;
            end
            OPC_OP: begin
                ctrl_d.alu_op   = alu_from_f3(funct3, funct7_b5);
                ctrl_d.regwrite = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            default: begin
                ctrl_d.illegal  = 1'b1;
            end
        endcase
    end

    assign wb_hit_rs1 = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_idx);
    assign wb_hit_rs2 = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_idx);

    // Operand read: x0 is hardwired to zero; the bypass build forwards a same-cycle write-back.
    always_comb begin
        rs1_rd = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
        rs2_rd = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_hit_rs1) rs1_rd = wb_data_i;
        if (wb_hit_rs2) rs2_rd = wb_data_i;
`endif
    end

    assign hazard_lu = valid_i && valid_q && ctrl_q.memread && (rd_q != 5'd0) &&
                       ((use_rs1 && (rd_q == rs1_idx)) || (use_rs2 && (rd_q == rs2_idx)));

`ifdef DECODE_WB_BYPASS_EN
    assign hazard_wb = 1'b0;
`else
    // Without forwarding, wait one cycle so the write lands in the array before reading.
    assign hazard_wb = valid_i && ((use_rs1 && wb_hit_rs1) || (use_rs2 && wb_hit_rs2));
`endif

    // A flush squashes the instruction anyway, so holding fetch would only waste a cycle.
    assign stall_o = !reset_i && !flush_i && (hazard_lu || hazard_wb);

    // Register file: synchronous clear, write port from WB (x0 writes dropped).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    // ID/EX register: control gated to a bubble on flush, stall or no input; data loaded freely.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
        end else begin
            pc_q       <= pc_i;
            rs1_data_q <= rs1_rd;
            rs2_data_q <= rs2_rd;
            imm_q      <= imm_d;
            rs1_q      <= rs1_idx;
            rs2_q      <= rs2_idx;
            rd_q       <= rd_idx;
            funct3_q   <= funct3;
            if (flush_i || stall_o || !valid_i) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl_d;
            end
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign imm_o      = imm_q;
    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign rd_o       = rd_q;
    assign funct3_o   = funct3_q;
    assign alu_op_o   = ctrl_q.alu_op;
    assign alusrc_o   = ctrl_q.alusrc;
    assign auipc_o    = ctrl_q.auipc;
    assign memread_o  = ctrl_q.memread;
    assign memwrite_o = ctrl_q.memwrite;
    assign regwrite_o = ctrl_q.regwrite;
    assign memtoreg_o = ctrl_q.memtoreg;
    assign branch_o   = ctrl_q.branch;
    assign jump_o     = ctrl_q.jump;
    assign illegal_o  = ctrl_q.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Directed bench for pipeline_decode: reset, decode fields, load-use stall, WB collision, flush, x0, illegal.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later or after the next edge.
// Expected values are hand-computed encodings; the WB-collision expectation follows DECODE_WB_BYPASS_EN.
module tb_pipeline_decode;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;
    logic        alusrc_o;
    logic        auipc_o;
    logic        memread_o;
    logic        memwrite_o;
    logic        regwrite_o;
    logic        memtoreg_o;
    logic        branch_o;
    logic        jump_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_LW     = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADD3   = 32'h001101B3; // add  x3,x2,x1
    localparam logic [31:0] I_ADD5   = 32'h000202B3; // add  x5,x4,x0
    localparam logic [31:0] I_ADD7   = 32'h001003B3; // add  x7,x0,x1
    localparam logic [31:0] I_BEQ    = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_SRAI   = 32'h4030D413; // srai x8,x1,3
    localparam logic [31:0] I_LUI    = 32'h123454B7; // lui  x9,0x12345
    localparam logic [31:0] I_ILL    = 32'h0000007F;

    always #5 clk_i = ~clk_i;

    pipeline_decode dut (
        .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i), .pc_i(pc_i),
        .valid_i(valid_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
        .alu_op_o(alu_op_o), .alusrc_o(alusrc_o), .auipc_o(auipc_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .regwrite_o(regwrite_o),
        .memtoreg_o(memtoreg_o), .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic vld);
        instruction_i = ins;
        pc_i          = pc;
        valid_i       = vld;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; flush_i = 1'b0; wb_en_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
        drive(I_LW, 32'h40, 1'b1);
        tick(); tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", valid_o); end
        total++; if (regwrite_o !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%0h want=0", regwrite_o); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc_o); end
        total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL reset_imm got=%0h want=0", imm_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", stall_o); end
        reset_i = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_addi();
        drive(I_ADDI, 32'h0, 1'b1);
        tick();
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h want=1", valid_o); end
        total++; if (rd_o !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0h want=1", rd_o); end
        total++; if (imm_o !== 32'h5) begin bad++; $display("FAIL addi_imm got=%0h want=5", imm_o); end
        total++; if (alu_op_o !== 4'd0) begin bad++; $display("FAIL addi_alu got=%0h want=0", alu_op_o); end
        total++; if (alusrc_o !== 1'b1) begin bad++; $display("FAIL addi_alusrc got=%0h want=1", alusrc_o); end
        total++; if (regwrite_o !== 1'b1) begin bad++; $display("FAIL addi_regwrite got=%0h want=1", regwrite_o); end
        total++; if (memread_o !== 1'b0) begin bad++; $display("FAIL addi_memread got=%0h want=0", memread_o); end
    endtask

    task automatic test_load_use();
        drive(I_LW, 32'h4, 1'b1);
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_lw_nostall got=%0h want=0", stall_o); end
        tick();
        total++; if (memread_o !== 1'b1 || rd_o !== 5'd2) begin bad++; $display("FAIL lu_lw_issue memread=%0h rd=%0h want 1,2", memread_o, rd_o); end
        drive(I_ADD3, 32'h8, 1'b1);
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h want=1", stall_o); end
        tick();
        total++; if (valid_o !== 1'b0 || regwrite_o !== 1'b0) begin bad++; $display("FAIL lu_bubble valid=%0h regwrite=%0h want 0,0", valid_o, regwrite_o); end
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%0h want=0", stall_o); end
        tick();
        total++; if (valid_o !== 1'b1 || rs1_o !== 5'd2) begin bad++; $display("FAIL lu_add_issue valid=%0h rs1=%0h want 1,2", valid_o, rs1_o); end
        total++; if (rs2_o !== 5'd1 || rd_o !== 5'd3 || alusrc_o !== 1'b0) begin bad++; $display("FAIL lu_add_fields rs2=%0h rd=%0h alusrc=%0h want 1,3,0", rs2_o, rd_o, alusrc_o); end
        total++; if (pc_o !== 32'h8) begin bad++; $display("FAIL lu_add_pc got=%0h want=8", pc_o); end
    endtask

    task automatic test_wb_collision();
        // Idle cycle that also preloads x1 = 0x11.
        drive(32'h0, 32'h0, 1'b0);
        wb_en_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h11;
        tick();
        drive(I_ADD5, 32'h10, 1'b1);
        wb_en_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'hDEADBEEF;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wb_nostall got=%0h want=0", stall_o); end
        tick();
        wb_en_i = 1'b0;
        total++; if (valid_o !== 1'b1 || rs1_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_bypass valid=%0h rs1_data=%0h want 1,deadbeef", valid_o, rs1_data_o); end
`else
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wb_stall got=%0h want=1", stall_o); end
        tick();
        wb_en_i = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL wb_bubble valid=%0h stall=%0h want 0,0", valid_o, stall_o); end
        tick();
        total++; if (valid_o !== 1'b1 || rs1_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_after_stall valid=%0h rs1_data=%0h want 1,deadbeef", valid_o, rs1_data_o); end
`endif
        total++; if (rs2_data_o !== 32'h0 || rd_o !== 5'd5) begin bad++; $display("FAIL wb_fields rs2_data=%0h rd=%0h want 0,5", rs2_data_o, rd_o); end
    endtask

    task automatic test_x0();
        drive(I_ADD7, 32'h14, 1'b1);
        wb_en_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h7;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL x0_nostall got=%0h want=0", stall_o); end
        tick();
        wb_en_i = 1'b0;
        total++; if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h11) begin bad++; $display("FAIL x0_same rs1_data=%0h rs2_data=%0h want 0,11", rs1_data_o, rs2_data_o); end
        tick();
        total++; if (rs1_data_o !== 32'h0) begin bad++; $display("FAIL x0_after got=%0h want=0", rs1_data_o); end
    endtask

    task automatic test_flush();
        drive(I_LW, 32'h20, 1'b1);
        tick();
        drive(I_ADD3, 32'h24, 1'b1);
        flush_i = 1'b1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h want=0", stall_o); end
        tick();
        flush_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", valid_o); end
        total++; if ({alu_op_o, alusrc_o, auipc_o, memread_o, memwrite_o, regwrite_o, memtoreg_o, branch_o, jump_o, illegal_o} !== 13'h0)
            begin bad++; $display("FAIL flush_ctrl got=%0h want=0", {alu_op_o, alusrc_o, auipc_o, memread_o, memwrite_o, regwrite_o, memtoreg_o, branch_o, jump_o, illegal_o}); end
    endtask

    task automatic test_decode_misc();
        drive(I_BEQ, 32'h30, 1'b1);
        tick();
        total++; if (imm_o !== 32'hFFFFFFF8) begin bad++; $display("FAIL beq_imm got=%0h want=fffffff8", imm_o); end
        total++; if (branch_o !== 1'b1 || alu_op_o !== 4'd1 || regwrite_o !== 1'b0) begin bad++; $display("FAIL beq_ctrl branch=%0h alu=%0h regwrite=%0h want 1,1,0", branch_o, alu_op_o, regwrite_o); end
        drive(I_SRAI, 32'h34, 1'b1);
        tick();
        total++; if (alu_op_o !== 4'd7 || alusrc_o !== 1'b1 || rd_o !== 5'd8) begin bad++; $display("FAIL srai alu=%0h alusrc=%0h rd=%0h want 7,1,8", alu_op_o, alusrc_o, rd_o); end
        drive(I_LUI, 32'h38, 1'b1);
        tick();
        total++; if (imm_o !== 32'h12345000 || alu_op_o !== 4'd10 || regwrite_o !== 1'b1) begin bad++; $display("FAIL lui imm=%0h alu=%0h regwrite=%0h want 12345000,a,1", imm_o, alu_op_o, regwrite_o); end
        drive(I_ILL, 32'h3C, 1'b1);
        tick();
        total++; if (illegal_o !== 1'b1 || valid_o !== 1'b1) begin bad++; $display("FAIL illegal illegal=%0h valid=%0h want 1,1", illegal_o, valid_o); end
        total++; if (regwrite_o !== 1'b0 || memwrite_o !== 1'b0) begin bad++; $display("FAIL illegal_ctrl regwrite=%0h memwrite=%0h want 0,0", regwrite_o, memwrite_o); end
    endtask

    task automatic test_reset_mid_stall();
        drive(I_LW, 32'h50, 1'b1);
        tick();
        drive(I_ADD3, 32'h54, 1'b1);
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rms_stall got=%0h want=1", stall_o); end
        reset_i = 1'b1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rms_stall_in_reset got=%0h want=0", stall_o); end
        tick();
        reset_i = 1'b0;
        total++; if (valid_o !== 1'b0 || memread_o !== 1'b0) begin bad++; $display("FAIL rms_empty valid=%0h memread=%0h want 0,0", valid_o, memread_o); end
        // x1 held 0x11 before reset; the clear must have wiped it.
        drive(I_ADD7, 32'h58, 1'b1);
        tick();
        total++; if (valid_o !== 1'b1 || rs2_data_o !== 32'h0) begin bad++; $display("FAIL rms_rf_clear valid=%0h rs2_data=%0h want 1,0", valid_o, rs2_data_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_wb_collision();
        test_x0();
        test_flush();
        test_decode_misc();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_decode.md
Name: pipeline_decode

Overview:
- RV32I decode stage that consumes the instruction and PC produced by pipeline_fetch.
- Reads a 32x32 register file, generates the immediate and control signals, and registers everything into the ID/EX pipeline register.
- Detects load-use hazards and stalls fetch.
- Inserts bubbles on stall and on branch flush from EX.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register file depth; register index is 5 bits.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  reset; fixed as synchronous, active-high
- instruction_i  input  32  instruction from fetch
- pc_i  input  32  PC of instruction_i
- valid_i  input  1  instruction_i is valid
- flush_i  input  1  branch taken in EX; squash the instruction in decode
- wb_en_i  input  1  register file write enable from WB
- wb_rd_i  input  5  write-back destination
- wb_data_i  input  32  write-back data
- stall_o  output  1  combinational; fetch holds PC and instruction_i
- valid_o  output  1  ID/EX entry valid
- pc_o  output  32  registered PC
- rs1_data_o, rs2_data_o  output  32  registered operands
- imm_o  output  32  registered sign-extended immediate
- rs1_o, rs2_o, rd_o  output  5  registered register indices
- funct3_o  output  3  registered funct3
- alu_op_o  output  4  ALU operation
- alusrc_o  output  1  ALU operand B source: 1 = imm, 0 = rs2
- auipc_o  output  1  ALU operand A is PC
- memread_o, memwrite_o, regwrite_o, memtoreg_o, branch_o, jump_o  output  1  control
- illegal_o  output  1  unrecognised opcode

Behaviour:
- Reset, while reset_i=1 at a clock edge:
  - All outputs 0.
  - All 32 registers cleared.
  - stall_o is 0 during reset.
- Latency: 1 cycle from instruction_i to the ID/EX outputs.
- Register file:
  - Write at posedge when wb_en_i=1 and wb_rd_i≠0.
  - x0 always reads 0.
  - Read is combinational from instruction[19:15] and [24:20].
  - Same-cycle bypass: if wb_en_i=1, wb_rd_i≠0 and wb_rd_i equals a source index, the operand takes wb_data_i.
- Load-use hazard: stall_o=1 when all of the following hold:
  - valid_i=1
  - valid_o=1 and memread_o=1 and rd_o≠0
  - rd_o equals rs1 (for opcodes using rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP) or rs2 (BRANCH, STORE, OP).
- Next-state priority:
  1. reset
  2. flush_i: bubble (valid_o and all control = 0); stall_o forced 0
  3. stall: bubble
  4. valid_i=0: bubble
  5. otherwise: load the decoded instruction
- On a bubble, data fields (pc, imm, operands) may hold any value; control fields must be 0.
- Decode, by opcode:
  - LUI 0110111: U imm, alu PASSB, alusrc, regwrite.
  - AUIPC 0010111: U imm, ADD, auipc, alusrc, regwrite.
  - JAL 1101111: J imm, jump, regwrite.
  - JALR 1100111: I imm, jump, alusrc, regwrite.
  - BRANCH 1100011: B imm, branch, SUB.
  - LOAD 0000011: I imm, ADD, alusrc, memread, memtoreg, regwrite.
  - STORE 0100011: S imm, ADD, alusrc, memwrite.
  - OP-IMM 0010011: I imm, alusrc, regwrite; ALU from funct3; funct7[5] selects SRA only for funct3=101.
  - OP 0110011: ALU from funct3; funct7[5] selects SUB/SRA.
  - Any other opcode: illegal_o=1, valid_o=1, all other control 0.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- Immediates are sign-extended from instruction[31]. B and J immediates have bit 0 = 0.
- Reset mid-stall: the stall clears and the pipeline is empty next cycle.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: same-cycle WB bypass as above.
- Undefined: no bypass; the register file read returns the pre-write value. stall_o is also asserted when wb_en_i=1, wb_rd_i≠0 and wb_rd_i matches a used source. The bubble rule and flush priority are unchanged.

Test Plan:
- Reset then valid_i=1 with ADDI x1,x0,5 (0x00500093), pc_i=0x0 → next cycle: valid_o=1, rd_o=1, imm_o=5, alu_op_o=0, alusrc_o=1, regwrite_o=1.
- LW x2,0(x1) followed by ADD x3,x2,x1 → stall_o=1 for exactly 1 cycle; one bubble (valid_o=0, regwrite_o=0); then ADD issues with rs1_o=2.
- wb_en_i=1, wb_rd_i=4, wb_data_i=0xDEADBEEF in the same cycle as ADD x5,x4,x0:
  - With the macro: rs1_data_o=0xDEADBEEF.
  - Without the macro: one stall cycle, then 0xDEADBEEF.
- flush_i=1 together with valid_i=1 and a load-use condition → stall_o=0, next cycle valid_o=0 with all control 0.
- BEQ with imm=-8 (0xFE000CE3) → imm_o=0xFFFFFFF8, branch_o=1, alu_op_o=1. Write to x0 (wb_rd_i=0, data 7) → x0 still reads 0.
- Opcode 0x0000007F → illegal_o=1, regwrite_o=0, memwrite_o=0.
